// File: rtl/key_seq_pkg.sv
// Shared definitions for the serial-key sequencer.
//   - Address window constants (BA13/BA12) and the number of unlock reads.
//   - Sequencer state and bus-phase encodings, kept as plain localparam
//     constants so they map one-to-one onto legacy state registers.
//   - build_ba(): forms the 14-bit bus address for a BA7..BA4 nibble.
package key_seq_pkg;

    localparam logic KEY_BA13         = 1'b0;
    localparam logic KEY_BA12         = 1'b1;
    localparam int   KEY_UNLOCK_READS = 4;
    localparam int   KEY_BA_W         = 14;

    // Sequencer states (key_seq_ctrl). ST_READ covers the ADDR and STB
    // phases of unlock and data reads; the phases themselves live in
    // key_bus_cycle. ST_PAR is the parity read (parity builds only).
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t ST_IDLE = 3'd0;
    localparam seq_state_t ST_REQ  = 3'd1;
    localparam seq_state_t ST_READ = 3'd2;
    localparam seq_state_t ST_PAR  = 3'd3;
    localparam seq_state_t ST_DONE = 3'd4;

    // Single-read phases (key_bus_cycle).
    typedef logic [1:0] bus_phase_t;
    localparam bus_phase_t PH_IDLE = 2'd0;
    localparam bus_phase_t PH_ADDR = 2'd1;
    localparam bus_phase_t PH_STB  = 2'd2;

    // ba[13:12] select the key window, ba[7:4] carry the nibble, rest 0.
    function automatic logic [KEY_BA_W-1:0] build_ba(input logic [3:0] nib);
        return {KEY_BA13, KEY_BA12, 4'b0000, nib, 4'b0000};
    endfunction

endpackage

// File: rtl/key_seq_ctrl_if.sv
// Local-bus side of the key sequencer.
//   bus_req  master->arbiter  bus request
//   bus_gnt  arbiter->master  bus grant
//   ba       master->decoder  14-bit bus address
//   br_w     master->decoder  read/write line (always read)
//   sser_n   master->decoder  key select, active low
//   sdrd     decoder->master  serial data bit
interface key_seq_ctrl_if;
    import key_seq_pkg::*;

    logic                bus_req;
    logic                bus_gnt;
    logic [KEY_BA_W-1:0] ba;
    logic                br_w;
    logic                sser_n;
    logic                sdrd;

    modport master (output bus_req, ba, br_w, sser_n, input bus_gnt, sdrd);
    modport slave  (input bus_req, ba, br_w, sser_n, output bus_gnt, sdrd);

endinterface

// File: rtl/key_bus_cycle.sv
// Single-read engine: one ADDR cycle (ba driven, sser_n high) followed by
// WAIT_CYC STB cycles (sser_n low, ba held).
//   launch  start a read at nibble nib (may coincide with fin so reads run
//           back to back with one ADDR cycle in between)
//   fin     combinational: this edge is the final STB edge, sample sdrd now
//   abort   combinational: grant lost in ADDR/STB, the read is dropped
//   ba, sser_n are registered.
module key_bus_cycle
    import key_seq_pkg::*;
#(
    parameter int WAIT_CYC = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                launch,
    input  logic [3:0]          nib,
    input  logic                bus_gnt,
    output logic [KEY_BA_W-1:0] ba,
    output logic                sser_n,
    output logic                fin,
    output logic                abort
);

    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYC - 1);

    bus_phase_t          phase_q, phase_d;
    logic [2:0]          wcnt_q, wcnt_d;
    logic [KEY_BA_W-1:0] ba_q, ba_d;
    logic                sser_n_q, sser_n_d;

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        phase_d  = phase_q;
        wcnt_d   = wcnt_q;
        ba_d     = ba_q;
        sser_n_d = sser_n_q;
        fin      = 1'b0;
        abort    = 1'b0;

        case (phase_q)
            PH_ADDR: begin
                if (!bus_gnt) begin
                    abort    = 1'b1;
                    phase_d  = PH_IDLE;
                    ba_d     = '0;
                end else begin
                    phase_d  = PH_STB;
                    sser_n_d = 1'b0;
                    wcnt_d   = '0;
                end
            end
            PH_STB: begin
                if (!bus_gnt) begin
                    abort    = 1'b1;
                    phase_d  = PH_IDLE;
                    sser_n_d = 1'b1;
                    ba_d     = '0;
                end else if (wcnt_q == WAIT_LAST) begin
                    fin      = 1'b1;
                    phase_d  = PH_IDLE;
                    sser_n_d = 1'b1;
                    ba_d     = '0;
                end else begin
                    wcnt_d   = wcnt_q + 3'd1;
                end
            end
            default: ;
        endcase

        // A launch overrides the idle return so the next ADDR follows the
        // final STB cycle directly.
        if (launch) begin
            phase_d  = PH_ADDR;
            ba_d     = build_ba(nib);
            sser_n_d = 1'b1;
        end
    end

    // NOTE: sequential state takes non-blocking assignments only; all next
    // values were settled in the always_comb above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_IDLE;
            wcnt_q   <= '0;
            ba_q     <= '0;
            sser_n_q <= 1'b1;
        end else begin
            phase_q  <= phase_d;
            wcnt_q   <= wcnt_d;
            ba_q     <= ba_d;
            sser_n_q <= sser_n_d;
        end
    end

    assign ba     = ba_q;
    assign sser_n = sser_n_q;

endmodule

// File: rtl/key_seq_ctrl.sv
// Host-side sequencer for the serial-key decoder in the BA13=0/BA12=1
// window. On start it requests the bus, issues four unlock reads
// (unlock_seq nibbles, MSB nibble first) and NBITS data reads at data_nib,
// shifting each returned sdrd bit into result (first bit ends in the MSB).
// Ports: clk, rst_n (async, active low); host side start, unlock_seq,
// data_nib, busy, done (1-cycle pulse), err, result; bus side via the
// key_seq_ctrl_if master modport. All outputs are registered.
// Optional build macro KEY_SEQ_PARITY_EN: one extra read after the data
// reads whose bit must equal the XOR of result, else err is set.
module key_seq_ctrl
    import key_seq_pkg::*;
#(
    parameter int NBITS    = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           unlock_seq,
    input  logic [3:0]            data_nib,
    key_seq_ctrl_if.master        bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [NBITS-1:0]      result
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_READ  = CNT_W'(KEY_UNLOCK_READS + NBITS - 1);
    localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(KEY_UNLOCK_READS);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      unlock_q, unlock_d;
    logic [3:0]       nib_q, nib_d;
    logic [NBITS-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             bus_req_q, bus_req_d;

    logic                launch;
    logic [3:0]          launch_nib;
    logic                fin;
    logic                abort;
    logic [KEY_BA_W-1:0] ba_w;
    logic                sser_n_w;
    logic [15:0]         unlock_shift;

    // Unlock nibble for read cnt_q+1, moved into the top nibble.
    assign unlock_shift = unlock_q << {cnt_q[1:0] + 2'd1, 2'b00};

    key_bus_cycle #(.WAIT_CYC(WAIT_CYC)) u_cycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .launch  (launch),
        .nib     (launch_nib),
        .bus_gnt (bus.bus_gnt),
        .ba      (ba_w),
        .sser_n  (sser_n_w),
        .fin     (fin),
        .abort   (abort)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        unlock_d   = unlock_q;
        nib_d      = nib_q;
        result_d   = result_q;
        err_d      = err_q;
        done_d     = done_q;
        busy_d     = busy_q;
        bus_req_d  = bus_req_q;
        launch     = 1'b0;
        launch_nib = nib_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_REQ;
                    busy_d    = 1'b1;
                    bus_req_d = 1'b1;
                    err_d     = 1'b0;
                    result_d  = '0;
                    cnt_d     = '0;
                    unlock_d  = unlock_seq;
                    nib_d     = data_nib;
                end
            end
            ST_REQ: begin
                if (bus.bus_gnt) begin
                    state_d    = ST_READ;
                    launch     = 1'b1;
                    launch_nib = unlock_q[15:12];
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    result_d  = '0;
                    bus_req_d = 1'b0;
                end else if (fin) begin
                    if (cnt_q >= FIRST_DATA) begin
                        result_d = (result_q << 1) | NBITS'(bus.sdrd);
                    end
                    if (cnt_q == LAST_READ) begin
`ifdef KEY_SEQ_PARITY_EN
                        state_d    = ST_PAR;
                        launch     = 1'b1;
                        launch_nib = nib_q;
`else
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        bus_req_d  = 1'b0;
`endif
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        launch     = 1'b1;
                        launch_nib = (cnt_q < FIRST_DATA - CNT_W'(1)) ? unlock_shift[15:12] : nib_q;
                    end
                end
            end
`ifdef KEY_SEQ_PARITY_EN
            ST_PAR: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    result_d  = '0;
                    bus_req_d = 1'b0;
                end else if (fin) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    bus_req_d = 1'b0;
                    err_d     = bus.sdrd ^ (^result_q);
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the captured unlock/data nibbles are ordinary registers rather
    // than a memory, so they are reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            unlock_q  <= '0;
            nib_q     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            unlock_q  <= unlock_d;
            nib_q     <= nib_d;
            result_q  <= result_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            bus_req_q <= bus_req_d;
        end
    end

    assign bus.bus_req = bus_req_q;
    assign bus.ba      = ba_w;
    assign bus.br_w    = 1'b1;
    assign bus.sser_n  = sser_n_w;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;

endmodule
